// File: rtl/axi4lite_apb_master.sv
// AXI4-Lite slave to APB master bridge: one-entry AW/W/AR holding slots feed an
// APB SETUP/ACCESS sequencer with at most one transfer in flight. Read and write
// arbitration alternates when both kinds are pending. An optional ACCESS watchdog
// ends a stuck transfer with SLVERR.
// Latency: a launch takes 3 cycles from the AXI handshake to B/R valid (SETUP,
// one ACCESS cycle, response). Each PREADY=0 cycle adds one cycle.
// Backpressure: xREADY is low while the matching slot is full. BVALID/RVALID are
// held with a stable payload until BREADY/RREADY.
// Ports: PCLK/PRESET (sync, active-high); AXI4-Lite AW/W/B/AR/R channels;
// APB master PADDR/PWRITE/PWDATA/PSTRB/PPROT/PSEL/PENABLE, slave returns
// PRDATA/PREADY/PSLVERR. All outputs come straight from flops.
module axi4lite_apb_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 0
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic [AW-1:0]   AWADDR,
  input  logic [2:0]      AWPROT,
  input  logic            AWVALID,
  output logic            AWREADY,
  input  logic [DW-1:0]   WDATA,
  input  logic [DW/8-1:0] WSTRB,
  input  logic            WVALID,
  output logic            WREADY,
  output logic [1:0]      BRESP,
  output logic            BVALID,
  input  logic            BREADY,
  input  logic [AW-1:0]   ARADDR,
  input  logic [2:0]      ARPROT,
  input  logic            ARVALID,
  output logic            ARREADY,
  output logic [DW-1:0]   RDATA,
  output logic [1:0]      RRESP,
  output logic            RVALID,
  input  logic            RREADY,
  output logic [AW-1:0]   PADDR,
  output logic            PWRITE,
  output logic [DW-1:0]   PWDATA,
  output logic [DW/8-1:0] PSTRB,
  output logic [2:0]      PPROT,
  output logic            PSEL,
  output logic            PENABLE,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PREADY,
  input  logic            PSLVERR
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The watchdog fires in the ACCESS cycle whose count is TIMEOUT-1, so the
  // transfer spends exactly TIMEOUT cycles in ACCESS.
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              aw_full, w_full, ar_full;
  logic [AW-1:0]     aw_addr, ar_addr;
  logic [2:0]        aw_prot, ar_prot;
  logic [DW-1:0]     w_data;
  logic [DW/8-1:0]   w_strb;
  logic              cur_wr;   // kind of the transfer in flight
  logic              prio;     // 0: write wins the next tie, 1: read wins
  logic [CW-1:0]     to_cnt;

  logic pend_wr, pend_rd, to_hit;
  logic launch, launch_wr, finish, timed_out;

  assign pend_wr = aw_full & w_full;
  assign pend_rd = ar_full;
  assign to_hit  = (TIMEOUT != 0) && (to_cnt == TO_LAST);

  assign AWREADY = ~aw_full;
  assign WREADY  = ~w_full;
  assign ARREADY = ~ar_full;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    launch_wr = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (pend_wr || pend_rd) begin
          launch    = 1'b1;
          launch_wr = pend_wr && (!pend_rd || !prio);
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        // PREADY takes precedence over a watchdog expiring in the same cycle.
        if (PREADY) begin
          finish    = 1'b1;
          state_nxt = RESP;
        end else if (to_hit) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if ((BVALID && BREADY) || (RVALID && RREADY)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      aw_full <= 1'b0;  w_full  <= 1'b0;  ar_full <= 1'b0;
      aw_addr <= '0;    aw_prot <= '0;    ar_addr <= '0;   ar_prot <= '0;
      w_data  <= '0;    w_strb  <= '0;
      cur_wr  <= 1'b0;  prio    <= 1'b0;  to_cnt  <= '0;
      PADDR   <= '0;    PWRITE  <= 1'b0;  PWDATA  <= '0;   PSTRB   <= '0;
      PPROT   <= '0;    PSEL    <= 1'b0;  PENABLE <= 1'b0;
      BVALID  <= 1'b0;  BRESP   <= '0;
      RVALID  <= 1'b0;  RRESP   <= '0;    RDATA   <= '0;
    end else begin
      if (AWVALID && !aw_full) begin
        aw_full <= 1'b1;
        aw_addr <= AWADDR;
        aw_prot <= AWPROT;
      end
      if (WVALID && !w_full) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      if (ARVALID && !ar_full) begin
        ar_full <= 1'b1;
        ar_addr <= ARADDR;
        ar_prot <= ARPROT;
      end

      if (launch) begin
        PSEL    <= 1'b1;
        PENABLE <= 1'b0;
        PWRITE  <= launch_wr;
        cur_wr  <= launch_wr;
        if (pend_wr && pend_rd) prio <= ~prio;
        if (launch_wr) begin
          PADDR  <= aw_addr;
          PPROT  <= aw_prot;
          PWDATA <= w_data;
          PSTRB  <= w_strb;
        end else begin
          // PWDATA deliberately keeps the last write data on reads.
          PADDR <= ar_addr;
          PPROT <= ar_prot;
          PSTRB <= '0;
        end
      end

      if (state == SETUP) begin
        PENABLE <= 1'b1;
        to_cnt  <= '0;
      end
      if (state == ACCESS && !PREADY) to_cnt <= to_cnt + CW'(1);

      // Slots are released on entry to RESP, so the master can queue the
      // next request while this response waits for BREADY/RREADY.
      if (finish) begin
        PSEL    <= 1'b0;
        PENABLE <= 1'b0;
        if (cur_wr) begin
          BVALID  <= 1'b1;
          BRESP   <= (timed_out || PSLVERR) ? 2'b10 : 2'b00;
          aw_full <= 1'b0;
          w_full  <= 1'b0;
        end else begin
          RVALID  <= 1'b1;
          RRESP   <= (timed_out || PSLVERR) ? 2'b10 : 2'b00;
          RDATA   <= timed_out ? '0 : PRDATA;
          ar_full <= 1'b0;
        end
      end

      if (BVALID && BREADY) BVALID <= 1'b0;
      if (RVALID && RREADY) RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4lite_apb_master.sv
// Scoreboard bench for axi4lite_apb_master: directed stimulus pushes expected
// APB transfers and B/R responses into queues; monitor processes pop and
// compare whenever the DUT presents a transfer or a response.
module tb_axi4lite_apb_master;

  logic        PCLK, PRESET;
  logic [31:0] AWADDR;  logic [2:0] AWPROT;  logic AWVALID; logic AWREADY;
  logic [31:0] WDATA;   logic [3:0] WSTRB;   logic WVALID;  logic WREADY;
  logic [1:0]  BRESP;   logic BVALID;        logic BREADY;
  logic [31:0] ARADDR;  logic [2:0] ARPROT;  logic ARVALID; logic ARREADY;
  logic [31:0] RDATA;   logic [1:0] RRESP;   logic RVALID;  logic RREADY;
  logic [31:0] PADDR;   logic PWRITE;        logic [31:0] PWDATA;
  logic [3:0]  PSTRB;   logic [2:0] PPROT;   logic PSEL;    logic PENABLE;
  logic [31:0] PRDATA;  logic PREADY;        logic PSLVERR;

  axi4lite_apb_master #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen with empty scoreboard at %0t", name, $time);
  endtask

  // APB slave model: PREADY rises after wait_n ACCESS cycles unless stuck.
  int acc_cnt = 0;
  int wait_n  = 0;
  logic stuck = 1'b0;
  always @(posedge PCLK) begin
    if (PSEL && PENABLE) acc_cnt <= acc_cnt + 1;
    else                 acc_cnt <= 0;
  end
  assign PREADY = !stuck && (acc_cnt >= wait_n);

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          acc;   // expected ACCESS cycles, -1 for an aborted transfer
  } apb_exp_t;
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  apb_exp_t   apb_q[$];
  logic [1:0] b_q[$];
  r_exp_t     r_q[$];

  function automatic apb_exp_t mk(bit wr, logic [31:0] a, logic [31:0] d,
                                  logic [3:0] s, logic [2:0] p, int acc);
    apb_exp_t e;
    e.wr = wr; e.addr = a; e.wdata = d; e.strb = s; e.prot = p; e.acc = acc;
    return e;
  endfunction

  function automatic r_exp_t mkr(logic [31:0] d, logic [1:0] r);
    r_exp_t e;
    e.data = d; e.resp = r;
    return e;
  endfunction

  // APB monitor
  initial begin
    apb_exp_t cur;
    bit have_cur = 0;
    bit in_acc = 0;
    int acc_seen = 0;
    forever begin
      @(negedge PCLK);
      if (in_acc && !(PSEL && PENABLE)) begin
        if (cur.acc >= 0) chk("apb_access_cycles", acc_seen, cur.acc);
        in_acc = 0;
        have_cur = 0;
      end
      if (PSEL && !PENABLE) begin
        if (apb_q.size() == 0) unexpected("apb_setup");
        else begin
          cur = apb_q.pop_front();
          have_cur = 1;
          acc_seen = 0;
          chk("apb_pwrite", PWRITE, cur.wr);
          chk("apb_paddr",  PADDR,  cur.addr);
          chk("apb_pwdata", PWDATA, cur.wdata);
          chk("apb_pstrb",  PSTRB,  cur.strb);
          chk("apb_pprot",  PPROT,  cur.prot);
        end
      end else if (PSEL && PENABLE && have_cur) begin
        acc_seen++;
        in_acc = 1;
        chk("apb_paddr_stable",  PADDR,  cur.addr);
        chk("apb_pwrite_stable", PWRITE, cur.wr);
        chk("apb_pwdata_stable", PWDATA, cur.wdata);
        chk("apb_pstrb_stable",  PSTRB,  cur.strb);
      end
    end
  end

  // B monitor
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge PCLK);
      if (BVALID && BREADY) begin
        if (b_q.size() == 0) unexpected("b_resp");
        else begin
          e = b_q.pop_front();
          chk("bresp", BRESP, e);
        end
      end
    end
  end

  // R monitor
  initial begin
    r_exp_t e;
    forever begin
      @(negedge PCLK);
      if (RVALID && RREADY) begin
        if (r_q.size() == 0) unexpected("r_resp");
        else begin
          e = r_q.pop_front();
          chk("rdata", RDATA, e.data);
          chk("rresp", RRESP, e.resp);
        end
      end
    end
  end

  // Drives the requested channels at once and holds each until accepted.
  task automatic axi_send(input bit do_aw, input bit do_w, input bit do_ar,
                          input logic [31:0] awa, input logic [2:0] awp,
                          input logic [31:0] wd, input logic [3:0] ws,
                          input logic [31:0] ara, input logic [2:0] arp);
    int n;
    bit f_aw, f_w, f_ar;
    AWADDR = awa; AWPROT = awp; WDATA = wd; WSTRB = ws; ARADDR = ara; ARPROT = arp;
    AWVALID = do_aw; WVALID = do_w; ARVALID = do_ar;
    n = 0;
    while ((AWVALID || WVALID || ARVALID) && n < 50) begin
      f_aw = AWVALID && AWREADY;
      f_w  = WVALID && WREADY;
      f_ar = ARVALID && ARREADY;
      @(posedge PCLK); #1;
      if (f_aw) AWVALID = 1'b0;
      if (f_w)  WVALID  = 1'b0;
      if (f_ar) ARVALID = 1'b0;
      n++;
    end
    chk("axi_accept", {AWVALID, WVALID, ARVALID}, 3'b000);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((apb_q.size() + b_q.size() + r_q.size()) != 0 && n < 200) begin
      @(posedge PCLK);
      n++;
    end
    chk(name, apb_q.size() + b_q.size() + r_q.size(), 0);
    repeat (2) @(posedge PCLK);
    #1;
  endtask

  task automatic wait_rvalid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!RVALID && n < 30);
    chk(name, RVALID, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    PRESET = 1'b1;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    ARADDR = '0; ARPROT = '0; ARVALID = 1'b0;
    BREADY = 1'b1; RREADY = 1'b1;
    PRDATA = '0; PSLVERR = 1'b0;

    // Reset state
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", PSEL, 1'b0);       chk("rst_penable", PENABLE, 1'b0);
    chk("rst_pwrite", PWRITE, 1'b0);   chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_rvalid", RVALID, 1'b0);   chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);  chk("rst_pstrb", PSTRB, 4'h0);
    chk("rst_pprot", PPROT, 3'h0);     chk("rst_bresp", BRESP, 2'b00);
    chk("rst_rresp", RRESP, 2'b00);    chk("rst_rdata", RDATA, 32'h0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    @(posedge PCLK); #1;

    // 1: write, AW and W together, PREADY high, minimum latency
    apb_q.push_back(mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 1));
    b_q.push_back(2'b00);
    axi_send(1, 1, 0, 32'h10, 3'b000, 32'hDEADBEEF, 4'hF, 32'h0, 3'b000);
    @(negedge PCLK);
    chk("t1_idle_psel", PSEL, 1'b0);
    @(negedge PCLK);
    chk("t1_setup", {PSEL, PENABLE}, 2'b10);
    chk("t1_awready_busy", AWREADY, 1'b0);
    @(negedge PCLK);
    chk("t1_access", {PSEL, PENABLE}, 2'b11);
    chk("t1_bvalid_early", BVALID, 1'b0);
    @(negedge PCLK);
    chk("t1_bvalid", BVALID, 1'b1);
    chk("t1_ready_back", {AWREADY, WREADY}, 2'b11);
    chk("t1_psel_drop", PSEL, 1'b0);
    @(posedge PCLK); #1;
    wait_drain("t1_drain");

    // 2: read with two wait states, RVALID held under RREADY=0
    RREADY = 1'b0;
    wait_n = 2;
    PRDATA = 32'h12345678;
    apb_q.push_back(mk(0, 32'h24, 32'hDEADBEEF, 4'h0, 3'b000, 3));
    r_q.push_back(mkr(32'h12345678, 2'b00));
    axi_send(0, 0, 1, 32'h0, 3'b000, 32'h0, 4'h0, 32'h24, 3'b000);
    wait_rvalid("t2_rvalid");
    for (int i = 0; i < 5; i++) begin
      chk("t2_rvalid_hold", RVALID, 1'b1);
      chk("t2_rdata_hold", RDATA, 32'h12345678);
      @(negedge PCLK);
    end
    @(posedge PCLK); #1;
    RREADY = 1'b1;
    wait_drain("t2_drain");
    wait_n = 0;

    // 3: W three cycles before AW, slave error
    PSLVERR = 1'b1;
    apb_q.push_back(mk(1, 32'h40, 32'h0BADF00D, 4'h3, 3'b010, 1));
    b_q.push_back(2'b10);
    axi_send(0, 1, 0, 32'h0, 3'b000, 32'h0BADF00D, 4'h3, 32'h0, 3'b000);
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      chk("t3_no_psel", PSEL, 1'b0);
      @(posedge PCLK); #1;
    end
    axi_send(1, 0, 0, 32'h40, 3'b010, 32'h0BADF00D, 4'h3, 32'h0, 3'b000);
    wait_drain("t3_drain");
    PSLVERR = 1'b0;

    // 4: write+read pending together twice -> write, read, read, write
    PRDATA = 32'h0000CAFE;
    apb_q.push_back(mk(1, 32'h100, 32'h11111111, 4'hF, 3'b000, 1));
    apb_q.push_back(mk(0, 32'h200, 32'h11111111, 4'h0, 3'b100, 1));
    b_q.push_back(2'b00);
    r_q.push_back(mkr(32'h0000CAFE, 2'b00));
    axi_send(1, 1, 1, 32'h100, 3'b000, 32'h11111111, 4'hF, 32'h200, 3'b100);
    wait_drain("t4a_drain");
    apb_q.push_back(mk(0, 32'h400, 32'h11111111, 4'h0, 3'b101, 1));
    apb_q.push_back(mk(1, 32'h300, 32'h22222222, 4'hC, 3'b001, 1));
    b_q.push_back(2'b00);
    r_q.push_back(mkr(32'h0000CAFE, 2'b00));
    axi_send(1, 1, 1, 32'h300, 3'b001, 32'h22222222, 4'hC, 32'h400, 3'b101);
    wait_drain("t4b_drain");

    // 5: watchdog, PREADY stuck low
    stuck = 1'b1;
    PRDATA = 32'hAAAA5555;
    apb_q.push_back(mk(0, 32'h80, 32'h22222222, 4'h0, 3'b001, 4));
    r_q.push_back(mkr(32'h0, 2'b10));
    axi_send(0, 0, 1, 32'h0, 3'b000, 32'h0, 4'h0, 32'h80, 3'b001);
    wait_rvalid("t5_rvalid");
    chk("t5_psel_drop", PSEL, 1'b0);
    @(posedge PCLK); #1;
    wait_drain("t5_drain");

    // 6: reset during ACCESS abandons the transfer
    apb_q.push_back(mk(1, 32'h500, 32'h33333333, 4'hF, 3'b000, -1));
    axi_send(1, 1, 0, 32'h500, 3'b000, 32'h33333333, 4'hF, 32'h0, 3'b000);
    begin
      int n;
      n = 0;
      do begin
        @(negedge PCLK);
        n++;
      end while (!(PSEL && PENABLE) && n < 20);
      chk("t6_in_access", {PSEL, PENABLE}, 2'b11);
    end
    #2 PRESET = 1'b1;
    @(negedge PCLK);
    chk("t6_rst_psel", {PSEL, PENABLE}, 2'b00);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    stuck = 1'b0;
    @(negedge PCLK);
    chk("t6_ready_after", {AWREADY, WREADY, ARREADY}, 3'b111);
    for (int i = 0; i < 5; i++) begin
      chk("t6_no_resp", {BVALID, RVALID, PSEL}, 3'b000);
      @(negedge PCLK);
    end
    chk("final_queues", apb_q.size() + b_q.size() + r_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
